// File: rtl/btisa_decode_stage.sv
// BTISA decode stage: decodes ternary instructions at acceptance and queues
// the decoded entries for execute, with HALT/resume, flush and illegal counting.

package ternary_pkg;
   typedef logic [1:0] trit_t;
   localparam trit_t T_ZERO    = 2'b00;
   localparam trit_t T_POS_ONE = 2'b01;
   localparam trit_t T_NEG_ONE = 2'b10;
endpackage

package btisa_pkg;
   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       alu_src;
      logic       halt;
      logic       ecall;
      logic       illegal;
      logic [1:0] branch_type;
      logic [2:0] alu_op;
   } ctrl_t;
endpackage

module btisa_decode_stage
   import ternary_pkg::*;
   import btisa_pkg::*;
#(
   parameter int unsigned REG_TRITS = 2,
   parameter int unsigned IMM_TRITS = 2,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned TAG_W     = 8
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [2*(3+2*REG_TRITS+IMM_TRITS)-1:0]      in_instr,
   input  logic [TAG_W-1:0]                            in_tag,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [TAG_W-1:0]                            out_tag,
   output logic [5:0]                                  out_opcode,
   output logic [2*REG_TRITS-1:0]                      out_rd,
   output logic [2*REG_TRITS-1:0]                      out_rs1,
   output logic [2*IMM_TRITS-1:0]                      out_rs2_imm,
   output logic                                        out_reg_write,
   output logic                                        out_mem_read,
   output logic                                        out_mem_write,
   output logic                                        out_branch,
   output logic                                        out_jump,
   output logic                                        out_alu_src,
   output logic                                        out_halt,
   output logic                                        out_ecall,
   output logic                                        out_illegal,
   output logic [1:0]                                  out_branch_type,
   output logic [2:0]                                  out_alu_op,
   input  logic                                        flush,
   input  logic                                        resume,
   output logic                                        halted,
   output logic [$clog2(DEPTH+1)-1:0]                  count,
   output logic [7:0]                                  illegal_count
);

   localparam int unsigned INSTR_TRITS = 3 + 2*REG_TRITS + IMM_TRITS;
   localparam int unsigned INSTR_W     = 2*INSTR_TRITS;
   localparam int unsigned REG_W       = 2*REG_TRITS;
   localparam int unsigned IMM_W       = 2*IMM_TRITS;
   localparam int unsigned CNT_W       = $clog2(DEPTH+1);
   localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {S_RUN, S_HALTED} state_t;

   state_t              state;
   ctrl_t               dec;
   logic [INSTR_TRITS-1:0] trit_bad;
   logic                bad_code;
   logic [5:0]          opcode;
   logic                push;
   logic                pop;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic [TAG_W-1:0]    tag_mem   [DEPTH];
   logic [INSTR_W-1:0]  instr_mem [DEPTH];
   ctrl_t               ctrl_mem  [DEPTH];
   logic [INSTR_W-1:0]  head_instr;
   ctrl_t               head_ctrl;

   // Flag any trit holding a code outside the three canonical values
   for (genvar g = 0; g < INSTR_TRITS; g++) begin : g_trit_chk
      assign trit_bad[g] = (in_instr[2*g+1:2*g] != T_ZERO) &&
                           (in_instr[2*g+1:2*g] != T_POS_ONE) &&
                           (in_instr[2*g+1:2*g] != T_NEG_ONE);
   end

   assign bad_code = |trit_bad;
   assign opcode   = in_instr[INSTR_W-1 -: 6];

   // Opcode decode; illegal encodings clear every other control
   always_comb begin
      dec = '0;
      case (opcode)
         {T_ZERO, T_ZERO, T_ZERO},
         {T_ZERO, T_POS_ONE, T_ZERO}:    begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b000; end
         {T_ZERO, T_ZERO, T_POS_ONE}:    begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b001; end
         {T_ZERO, T_ZERO, T_NEG_ONE}:    begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b010; end
         {T_ZERO, T_POS_ONE, T_POS_ONE}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b101; end
         {T_ZERO, T_POS_ONE, T_NEG_ONE}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b110; end
         {T_POS_ONE, T_ZERO, T_ZERO}:    begin dec.reg_write = 1'b1; dec.alu_op = 3'b011; end
         {T_POS_ONE, T_ZERO, T_POS_ONE}: begin dec.reg_write = 1'b1; dec.alu_op = 3'b100; end
         {T_POS_ONE, T_ZERO, T_NEG_ONE}: begin dec.reg_write = 1'b1; dec.alu_op = 3'b000; end
         {T_POS_ONE, T_POS_ONE, T_ZERO},
         {T_POS_ONE, T_POS_ONE, T_POS_ONE},
         {T_POS_ONE, T_POS_ONE, T_NEG_ONE}: begin dec.reg_write = 1'b1; dec.alu_op = 3'b010; end
         {T_ZERO, T_NEG_ONE, T_ZERO}:    begin dec.branch = 1'b1; dec.branch_type = 2'b01; dec.alu_op = 3'b001; end
         {T_ZERO, T_NEG_ONE, T_POS_ONE}: begin dec.branch = 1'b1; dec.branch_type = 2'b10; dec.alu_op = 3'b001; end
         {T_ZERO, T_NEG_ONE, T_NEG_ONE}: begin dec.branch = 1'b1; dec.branch_type = 2'b11; dec.alu_op = 3'b001; end
         {T_POS_ONE, T_NEG_ONE, T_ZERO},
         {T_POS_ONE, T_NEG_ONE, T_POS_ONE}: begin dec.jump = 1'b1; dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
         {T_POS_ONE, T_NEG_ONE, T_NEG_ONE}: begin dec.jump = 1'b1; dec.alu_src = 1'b1; end
         {T_NEG_ONE, T_ZERO, T_ZERO},
         {T_NEG_ONE, T_ZERO, T_NEG_ONE}: begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1; end
         {T_NEG_ONE, T_ZERO, T_POS_ONE},
         {T_NEG_ONE, T_POS_ONE, T_ZERO}: begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
         {T_NEG_ONE, T_POS_ONE, T_POS_ONE}: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
         {T_NEG_ONE, T_NEG_ONE, T_POS_ONE}: dec.halt  = 1'b1;
         {T_NEG_ONE, T_NEG_ONE, T_NEG_ONE}: dec.ecall = 1'b1;
         {T_NEG_ONE, T_NEG_ONE, T_ZERO}:    dec      = '0;
         default:                           dec.illegal = 1'b1;
      endcase
      if (bad_code) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign halted    = (state == S_HALTED);
   assign out_valid = (count != '0);
   assign in_ready  = !rst && !halted && !flush && ((count < CNT_W'(DEPTH)) || out_ready);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   // Run/halt state: HALT acceptance wins over a same-cycle resume
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_RUN;
      end else begin
         case (state)
            S_RUN:    if (push && dec.halt) state <= S_HALTED;
            S_HALTED: if (resume)           state <= S_RUN;
            default:                        state <= S_RUN;
         endcase
      end
   end

   // Queue pointers and occupancy; flush drops everything including a pop
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage, written with the decode result at acceptance
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr]   <= in_tag;
         instr_mem[wr_ptr] <= in_instr;
         ctrl_mem[wr_ptr]  <= dec;
      end
   end

   // Saturating count of accepted illegal instructions
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_count <= '0;
      end else if (push && dec.illegal && (illegal_count != 8'hFF)) begin
         illegal_count <= illegal_count + 8'd1;
      end
   end

   assign head_instr = out_valid ? instr_mem[rd_ptr] : '0;
   assign head_ctrl  = out_valid ? ctrl_mem[rd_ptr]  : '0;
   assign out_tag    = out_valid ? tag_mem[rd_ptr]   : '0;

   assign out_opcode      = head_instr[INSTR_W-1 -: 6];
   assign out_rd          = head_instr[INSTR_W-7 -: REG_W];
   assign out_rs1         = head_instr[INSTR_W-7-REG_W -: REG_W];
   assign out_rs2_imm     = head_instr[IMM_W-1:0];
   assign out_reg_write   = head_ctrl.reg_write;
   assign out_mem_read    = head_ctrl.mem_read;
   assign out_mem_write   = head_ctrl.mem_write;
   assign out_branch      = head_ctrl.branch;
   assign out_jump        = head_ctrl.jump;
   assign out_alu_src     = head_ctrl.alu_src;
   assign out_halt        = head_ctrl.halt;
   assign out_ecall       = head_ctrl.ecall;
   assign out_illegal     = head_ctrl.illegal;
   assign out_branch_type = head_ctrl.branch_type;
   assign out_alu_op      = head_ctrl.alu_op;

endmodule

// File: tb/tb_btisa_decode_stage.sv
// Randomized bench for btisa_decode_stage against a queue-based reference model.

module tb_btisa_decode_stage;
   import ternary_pkg::*;

   localparam int REG_TRITS   = 2;
   localparam int IMM_TRITS   = 2;
   localparam int DEPTH       = 2;
   localparam int TAG_W       = 8;
   localparam int INSTR_TRITS = 3 + 2*REG_TRITS + IMM_TRITS;
   localparam int INSTR_W     = 2*INSTR_TRITS;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [INSTR_W-1:0]  in_instr;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [TAG_W-1:0]    out_tag;
   logic [5:0]          out_opcode;
   logic [2*REG_TRITS-1:0] out_rd;
   logic [2*REG_TRITS-1:0] out_rs1;
   logic [2*IMM_TRITS-1:0] out_rs2_imm;
   logic out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump;
   logic out_alu_src, out_halt, out_ecall, out_illegal;
   logic [1:0]          out_branch_type;
   logic [2:0]          out_alu_op;
   logic                flush;
   logic                resume;
   logic                halted;
   logic [$clog2(DEPTH+1)-1:0] count;
   logic [7:0]          illegal_count;

   logic [13:0]         dut_ctrl;
   logic [INSTR_W-1:0]  dut_instr;

   typedef struct {
      logic [TAG_W-1:0]   tag;
      logic [INSTR_W-1:0] instr;
      logic [13:0]        ctrl;
   } ent_t;

   ent_t   q[$];
   logic   m_halted;
   int     m_ill;
   bit     m_init = 0;
   int     checks = 0;
   int     errors = 0;
   trit_t  bad_trit;

   btisa_decode_stage #(
      .REG_TRITS(REG_TRITS), .IMM_TRITS(IMM_TRITS), .DEPTH(DEPTH), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_tag(out_tag), .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1),
      .out_rs2_imm(out_rs2_imm), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write), .out_branch(out_branch), .out_jump(out_jump),
      .out_alu_src(out_alu_src), .out_halt(out_halt), .out_ecall(out_ecall),
      .out_illegal(out_illegal), .out_branch_type(out_branch_type), .out_alu_op(out_alu_op),
      .flush(flush), .resume(resume), .halted(halted), .count(count),
      .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   assign dut_ctrl  = {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump,
                       out_alu_src, out_halt, out_ecall, out_illegal, out_branch_type, out_alu_op};
   assign dut_instr = {out_opcode, out_rd, out_rs1, out_rs2_imm};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode from the balanced-ternary value of the opcode.
   // Bit order: rw mr mw br jp as ht ec il bt[1:0] ao[2:0]
   function automatic logic [13:0] ref_ctrl(input logic [INSTR_W-1:0] ins);
      logic [INSTR_W-1:0] s = ins;
      int   tv [INSTR_TRITS];
      bit   bad = 0;
      int   v;
      logic rw = 0, mr = 0, mw = 0, br = 0, jp = 0, as = 0, ht = 0, ec = 0, il = 0;
      int   bt = 0, ao = 0;
      for (int i = 0; i < INSTR_TRITS; i++) begin
         if (s[1:0] == T_ZERO)         tv[i] = 0;
         else if (s[1:0] == T_POS_ONE) tv[i] = 1;
         else if (s[1:0] == T_NEG_ONE) tv[i] = -1;
         else begin tv[i] = 0; bad = 1; end
         s = s >> 2;
      end
      v = 9*tv[INSTR_TRITS-1] + 3*tv[INSTR_TRITS-2] + tv[INSTR_TRITS-3];
      case (v)
         0:   begin rw = 1; as = 1; ao = 0; end
         1:   begin rw = 1; as = 1; ao = 1; end
         -1:  begin rw = 1; as = 1; ao = 2; end
         3:   begin rw = 1; as = 1; ao = 0; end
         4:   begin rw = 1; as = 1; ao = 5; end
         2:   begin rw = 1; as = 1; ao = 6; end
         9:   begin rw = 1; ao = 3; end
         10:  begin rw = 1; ao = 4; end
         8:   begin rw = 1; ao = 0; end
         11, 12, 13: begin rw = 1; ao = 2; end
         -3:  begin br = 1; bt = 1; ao = 1; end
         -2:  begin br = 1; bt = 2; ao = 1; end
         -4:  begin br = 1; bt = 3; ao = 1; end
         6, 7: begin jp = 1; rw = 1; as = 1; end
         5:   begin jp = 1; as = 1; end
         -9, -10: begin rw = 1; mr = 1; as = 1; end
         -8, -6:  begin mw = 1; as = 1; end
         -5:  begin rw = 1; as = 1; end
         -11: ht = 1;
         -13: ec = 1;
         -12: ;
         default: il = 1;
      endcase
      if (bad) return 14'b00000000100000;
      return {rw, mr, mw, br, jp, as, ht, ec, il, 2'(bt), 3'(ao)};
   endfunction

   function automatic trit_t rnd_trit();
      case ($urandom_range(2))
         0:       return T_ZERO;
         1:       return T_POS_ONE;
         default: return T_NEG_ONE;
      endcase
   endfunction

   // Opcode trits a,b,c (MSB first), random operands, optional bad trit
   function automatic logic [INSTR_W-1:0] mk(input trit_t a, input trit_t b, input trit_t c,
                                             input int p_bad);
      logic [INSTR_W-1:0] s;
      int pos;
      s = INSTR_W'({a, b, c});
      for (int i = 0; i < INSTR_TRITS-3; i++) s = (s << 2) | INSTR_W'(rnd_trit());
      if ($urandom_range(99) < p_bad) begin
         pos = $urandom_range(INSTR_TRITS-1);
         s = (s & ~(INSTR_W'(3) << (2*pos))) | (INSTR_W'(bad_trit) << (2*pos));
      end
      return s;
   endfunction

   function automatic logic [INSTR_W-1:0] rnd_instr(input int p_bad);
      return mk(rnd_trit(), rnd_trit(), rnd_trit(), p_bad);
   endfunction

   // One clock: drive at negedge, compare just after, advance model at posedge
   task automatic step(input logic v, input logic [INSTR_W-1:0] ins, input logic ordy,
                       input logic fl, input logic rs, input logic r);
      logic exp_ready;
      logic acc;
      logic pop;
      ent_t e;
      @(negedge clk);
      rst = r; in_valid = v; in_instr = ins; in_tag = TAG_W'($urandom);
      out_ready = ordy; flush = fl; resume = rs;
      #1;
      exp_ready = !m_halted && !fl && ((q.size() < DEPTH) || ordy);
      if (m_init) begin
         if (!r) check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
         check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
         check_eq("count", 32'(count), 32'(q.size()));
         check_eq("halted", 32'(halted), 32'(m_halted));
         check_eq("illegal_count", 32'(illegal_count), 32'(m_ill));
         if (q.size() != 0) begin
            check_eq("head_tag", 32'(out_tag), 32'(q[0].tag));
            check_eq("head_fields", 32'(dut_instr), 32'(q[0].instr));
            check_eq("head_ctrl", 32'(dut_ctrl), 32'(q[0].ctrl));
         end else begin
            check_eq("idle_ctrl", 32'(dut_ctrl), 32'd0);
         end
      end
      @(posedge clk);
      if (r) begin
         q.delete();
         m_halted = 1'b0;
         m_ill    = 0;
         m_init   = 1;
      end else if (m_init) begin
         acc = v && exp_ready;
         pop = (q.size() != 0) && ordy;
         e.tag = in_tag; e.instr = ins; e.ctrl = ref_ctrl(ins);
         if (fl) q.delete();
         else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
         end
         if (acc && e.ctrl[7]) m_halted = 1'b1;
         else if (rs)          m_halted = 1'b0;
         if (acc && e.ctrl[5] && m_ill < 255) m_ill++;
      end
   endtask

   initial begin
      logic [INSTR_W-1:0] add_i, min_i, blt_i, jr_i, halt_i, ill_i;
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0;
      out_ready = 1'b0; flush = 1'b0; resume = 1'b0;
      bad_trit = T_ZERO;
      for (int c = 0; c < 4; c++)
         if (2'(c) != T_ZERO && 2'(c) != T_POS_ONE && 2'(c) != T_NEG_ONE) bad_trit = 2'(c);

      add_i  = mk(T_ZERO, T_ZERO, T_ZERO, 0);
      min_i  = mk(T_POS_ONE, T_ZERO, T_ZERO, 0);
      blt_i  = mk(T_ZERO, T_NEG_ONE, T_NEG_ONE, 0);
      jr_i   = mk(T_POS_ONE, T_NEG_ONE, T_NEG_ONE, 0);
      halt_i = mk(T_NEG_ONE, T_NEG_ONE, T_POS_ONE, 0);
      ill_i  = mk(T_NEG_ONE, T_POS_ONE, T_NEG_ONE, 0);

      step(0, '0, 0, 0, 0, 1);
      step(0, '0, 0, 0, 0, 1);
      step(0, '0, 1, 0, 0, 0);
      // Ordered stream with execute always ready
      step(1, add_i, 1, 0, 0, 0);
      step(1, min_i, 1, 0, 0, 0);
      step(1, blt_i, 1, 0, 0, 0);
      step(1, jr_i,  1, 0, 0, 0);
      step(0, '0, 1, 0, 0, 0);
      // Fill with execute stalled, then push/pop while full
      for (int i = 0; i < 3; i++) step(1, rnd_instr(0), 0, 0, 0, 0);
      #1 check_eq("full_count", 32'(count), 32'd2);
      step(1, add_i, 1, 0, 0, 0);
      #1 check_eq("full_pushpop_count", 32'(count), 32'd2);
      for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0, 0);
      // HALT stalls the next instruction until resume
      step(1, halt_i, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, add_i, 1, 0, 0, 0);
      #1 check_eq("halt_state", 32'(halted), 32'd1);
      step(1, add_i, 1, 0, 1, 0);
      step(1, add_i, 1, 0, 0, 0);
      // Illegal opcode and non-canonical trit
      step(1, ill_i, 1, 0, 0, 0);
      step(1, mk(T_ZERO, T_ZERO, T_ZERO, 100), 1, 0, 0, 0);
      step(0, '0, 1, 0, 0, 0);
      // Flush with two queued entries and an offered instruction
      step(1, rnd_instr(0), 0, 0, 0, 0);
      step(1, add_i, 0, 0, 0, 0);
      step(1, add_i, 1, 1, 0, 0);
      #1 check_eq("flush_count", 32'(count), 32'd0);
      // Reset while halted with one entry queued
      step(1, halt_i, 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 0);
      step(0, '0, 0, 0, 0, 1);
      #1 check_eq("rst_halted", 32'(halted), 32'd0);
      // Saturate the illegal counter
      for (int i = 0; i < 300; i++)
         step(1, (i % 2 == 0) ? mk(T_NEG_ONE, T_POS_ONE, T_NEG_ONE, 0) : rnd_instr(100),
              1, 0, 0, 0);
      #1 check_eq("illegal_sat", 32'(illegal_count), 32'd255);
      // Randomized traffic
      for (int i = 0; i < 4000; i++)
         step($urandom_range(99) < 70, rnd_instr(5), $urandom_range(99) < 60,
              $urandom_range(99) < 3, $urandom_range(99) < 10, $urandom_range(499) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/btisa_decode_stage.md
# btisa_decode_stage

Registered, parametrised BTISA decode stage sitting between instruction fetch and execute in the balanced-ternary CPU pipeline. It accepts raw ternary instructions over a valid/ready handshake and decodes each one at acceptance. Decoded entries are held in a DEPTH-entry queue and presented to execute over a second valid/ready handshake. It adds illegal-encoding detection, a sticky HALT state with resume, flush, and a saturating illegal-instruction counter.

## Interface
Parameters:
- REG_TRITS, 2, trits per register field (rd, rs1)
- IMM_TRITS, 2, trits in rs2/imm field
- DEPTH, 2, decoded-entry queue depth (≥1)
- TAG_W, 8, width of the sideband tag (e.g. PC) carried with each instruction

Derived: INSTR_TRITS = 3 + 2·REG_TRITS + IMM_TRITS. Layout, MSB first: opcode[2:0], rd, rs1, rs2_imm.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  stage accepts this cycle
- in_instr  in  trit_t[INSTR_TRITS]  raw instruction
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  queue head valid
- out_ready  in  1  execute consumes head
- out_tag  out  TAG_W  head tag
- out_opcode / out_rd / out_rs1 / out_rs2_imm  out  trit_t fields  head fields, unmodified
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src, out_halt, out_ecall, out_illegal  out  1 each  head controls
- out_branch_type  out  2  00 none, 01 BEQ, 10 BNE, 11 BLT
- out_alu_op  out  3  000 ADD, 001 SUB, 010 NEG, 011 MIN, 100 MAX, 101 SHL, 110 SHR
- flush  in  1  discard all queued entries
- resume  in  1  leave HALTED
- halted  out  1  stage is in HALTED
- count  out  $clog2(DEPTH+1)  queued entries
- illegal_count  out  8  saturating count of accepted illegal instructions

## Operation
Trit values are T_NEG_ONE (-), T_ZERO (0), and T_POS_ONE (+) from ternary_pkg. All control outputs default to 0.

Decode (opcode, most significant trit first):
- 000 ADD/op000, 00+ SUB/001, 00- NEG/010, 0+0 MUL/000, 0++ SHL/101, 0+- SHR/110: reg_write=1, alu_src=1.
- +00 MIN/011, +0+ MAX/100, +0- XOR/000, ++0 INV, +++ PTI, ++- NTI (all 010): reg_write=1, alu_src=0.
- 0-0 BEQ, 0-+ BNE, 0-- BLT: branch=1, branch_type 01/10/11, alu_op=001.
- +-0 JAL and +-+ JALR: jump=1, reg_write=1, alu_src=1. +-- JR: jump=1, alu_src=1.
- -00 LD and -0- LDT: reg_write=1, mem_read=1, alu_src=1. -0+ ST and -+0 STT: mem_write=1, alu_src=1. -++ LUI: reg_write=1, alu_src=1. All use alu_op=000.
- --+ HALT: halt=1. --- ECALL: ecall=1. --0 NOP: no controls.
- -+- is illegal. Any trit in any field holding a non-canonical 2-bit code is also illegal. An illegal instruction sets illegal=1 and forces every other control to 0. Its fields are still passed through.

Handshake and queue:
- Accept condition: in_valid && in_ready.
- in_ready = !halted && !flush && (count < DEPTH || out_ready).
- Pop condition: out_valid && out_ready. Push and pop in the same cycle are legal, including when the queue is full; count is unchanged in that case.
- FIFO order is preserved. Head outputs come from registered storage, not from combinational decode of in_instr.

State machine (RUN, HALTED):
- RUN → HALTED when a HALT instruction is accepted. That HALT entry is still queued and delivered.
- HALTED → RUN on resume=1.
- resume in RUN has no effect.
- In HALTED, queued entries continue to drain.

Flush:
- flush=1 empties the queue at the edge, so count=0 and out_valid=0 next cycle.
- in_ready=0 during flush, so no entry is accepted.
- A pop in the same cycle is discarded.
- flush does not change the halted state.

illegal_count increments by 1 per accepted illegal instruction and saturates at 255. It is cleared only by rst.

## Timing
- Reset values: out_valid=0, count=0, halted=0, illegal_count=0; all head fields and controls 0. in_ready=1 from the cycle after rst deasserts.
- Latency: an instruction accepted at edge N is at the head with out_valid=1 after edge N (visible in cycle N+1) when the queue was empty.
- Throughput: 1 instruction per cycle sustained with out_ready=1, for any DEPTH ≥ 1.
- halted asserts in the cycle after HALT is accepted. The following cycle already has in_ready=0.
- resume and HALT accepted in the same cycle: the stage enters HALTED.
- rst mid-operation: the queue, state and counters return to reset values at that edge. Pending entries are lost.

## Test plan
- Reset, then stream ADD, MIN, BLT, JR with out_ready=1 → entries appear one cycle after acceptance in order:
  - ADD: alu_op 000, alu_src=1.
  - MIN: alu_op 011, alu_src=0.
  - BLT: branch_type 11, alu_op 001.
  - JR: jump=1, reg_write=0.
- DEPTH=2 with out_ready=0 and 3 instructions offered → 2 accepted, count=2, in_ready=0. Raising out_ready gives simultaneous push/pop and count stays 2.
- Accept HALT followed by an offered ADD → ADD is stalled (in_ready=0), HALT is delivered with halt=1, halted=1. A resume pulse is followed by ADD acceptance next cycle.
- Offer opcode -+- and then an instruction with a non-canonical trit code → out_illegal=1 with all other controls 0, illegal_count=2. After 300 illegal instructions, illegal_count=255.
- Queue holding 2 entries, flush with in_valid=1 and out_ready=1 → next cycle count=0 and out_valid=0, and nothing was accepted.
- Assert rst while HALTED with count=1 → next cycle halted=0, count=0, illegal_count=0.
